// File: rtl/chaos_pkg.sv
// ----------------------------------------------------------------------------
// chaos_pkg
//   Shared definitions for the chaos-cipher receiver datapath.
//   - SEED_IV_DEFAULT : initial "previous ciphertext" byte for chaining
//   - FP_* constants  : IEEE-754 single-precision reference values
//   - key_fold()      : folds a chaotic float sample into an 8-bit key byte
// ----------------------------------------------------------------------------
package chaos_pkg;

   localparam logic [7:0]  SEED_IV_DEFAULT = 8'hA5;

   localparam logic [31:0] FP_ONE          = 32'h3F80_0000;
   localparam logic [31:0] FP_HALF         = 32'h3F00_0000;
   localparam logic [31:0] FP_NEG_ONE      = 32'hBF80_0000;

   // Only the mantissa bits carry chaotic entropy; sign and exponent are
   // nearly constant across the sawtooth map's range, so they are dropped.
   function automatic logic [7:0] key_fold(input logic [31:0] sample);
      return sample[7:0] ^ sample[15:8] ^ {1'b0, sample[22:16]};
   endfunction

endpackage

// File: rtl/key_fifo.sv
// ----------------------------------------------------------------------------
// key_fifo
//   Synchronous 8-bit FIFO holding folded key bytes.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     push, push_data   write request and data (ignored when full)
//     pop               read request (ignored when empty)
//     pop_data          head entry (valid when !empty)
//     full, empty       status
//     level             occupancy, 0..DEPTH
//   A push into an empty FIFO becomes visible the following cycle.
// ----------------------------------------------------------------------------
module key_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   // Extra MSB separates full (MSBs differ) from empty (MSBs equal).
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        do_push;
   logic        do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level    = wr_ptr_q - rd_ptr_q;
   assign pop_data = mem[rd_ptr_q[AW-1:0]];

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset; pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/chaos_pixel_decrypt.sv
// ----------------------------------------------------------------------------
// chaos_pixel_decrypt
//   Receiver-side pixel decryptor. Chaotic float samples are folded into key
//   bytes and buffered; each ciphertext byte is XORed with the next key byte
//   (and, when chaining is built in, with the previous ciphertext byte).
//   Build option: define CHAIN_DIFFUSION_EN for p = c ^ k ^ prev_c with
//   prev_c restarting at SEED_IV each frame; otherwise p = c ^ k.
//   Ports:
//     clk, reset                       clock, asynchronous active-high reset
//     ks_valid, ks_data, ks_ready      chaotic sample stream in
//     ct_valid, ct_data, ct_ready      ciphertext byte stream in
//     pt_valid, pt_data, pt_ready      plaintext byte stream out
//     frame_done                       pulses with the last pixel of a frame
//     ks_level                         key FIFO occupancy
// ----------------------------------------------------------------------------
module chaos_pixel_decrypt
   import chaos_pkg::*;
#(
   parameter int unsigned PRECISION    = 32,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned FRAME_PIXELS = 65536,
   parameter logic [7:0]  SEED_IV      = SEED_IV_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ks_valid,
   input  logic [PRECISION-1:0]          ks_data,
   output logic                          ks_ready,
   input  logic                          ct_valid,
   input  logic [7:0]                    ct_data,
   output logic                          ct_ready,
   output logic                          pt_valid,
   output logic [7:0]                    pt_data,
   input  logic                          pt_ready,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   ks_level
);

   localparam int unsigned CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

   logic [31:0]      sample32;
   logic [7:0]       key_in;
   logic [7:0]       key_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fire;
   logic             last_pix;
   logic [7:0]       plain;

   logic             pt_valid_q;
   logic [7:0]       pt_data_q;
   logic             frame_done_q;
   logic [CNT_W-1:0] pix_cnt_q;

   assign sample32 = 32'(ks_data);
   assign key_in   = key_fold(sample32);

   key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_key_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ks_valid),
      .push_data (key_in),
      .pop       (fire),
      .pop_data  (key_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (ks_level)
   );

   assign ks_ready = !fifo_full;
   // Accept only when a key is available and the output slot frees this cycle.
   assign ct_ready = !fifo_empty && (!pt_valid_q || pt_ready);
   assign fire     = ct_valid && ct_ready;
   assign last_pix = (pix_cnt_q == LAST_PIX);

`ifdef CHAIN_DIFFUSION_EN
   logic [7:0] prev_c_q;

   assign plain = ct_data ^ key_head ^ prev_c_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_c_q <= SEED_IV;
      end else if (fire) begin
         prev_c_q <= last_pix ? SEED_IV : ct_data;
      end
   end
`else
   logic unused_seed_iv;

   assign unused_seed_iv = ^SEED_IV;
   assign plain          = ct_data ^ key_head;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pt_valid_q   <= 1'b0;
         pt_data_q    <= 8'h00;
         frame_done_q <= 1'b0;
         pix_cnt_q    <= '0;
      end else begin
         frame_done_q <= fire && last_pix;
         if (fire) begin
            pt_valid_q <= 1'b1;
            pt_data_q  <= plain;
            pix_cnt_q  <= last_pix ? '0 : pix_cnt_q + 1'b1;
         end else if (pt_ready) begin
            pt_valid_q <= 1'b0;
         end
      end
   end

   assign pt_valid   = pt_valid_q;
   assign pt_data    = pt_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_chaos_pixel_decrypt.sv
// ----------------------------------------------------------------------------
// tb_chaos_pixel_decrypt
//   Self-checking bench: directed scenarios plus randomized traffic, all
//   compared against a queue-based behavioural model of the decryptor.
//   Honours CHAIN_DIFFUSION_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_chaos_pixel_decrypt;
   import chaos_pkg::*;

   localparam int DEPTH = 8;
   localparam int FRAME = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ks_valid;
   logic [31:0] ks_data;
   logic        ks_ready;
   logic        ct_valid;
   logic [7:0]  ct_data;
   logic        ct_ready;
   logic        pt_valid;
   logic [7:0]  pt_data;
   logic        pt_ready;
   logic        frame_done;
   logic [3:0]  ks_level;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   byte unsigned m_keys[$];
   byte unsigned m_prev;
   int           m_pix;
   bit           m_pv;
   byte unsigned m_pd;
   bit           m_fd;

   always #5 clk = ~clk;

   chaos_pixel_decrypt #(
      .PRECISION    (32),
      .FIFO_DEPTH   (DEPTH),
      .FRAME_PIXELS (FRAME),
      .SEED_IV      (8'hA5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ks_valid   (ks_valid),
      .ks_data    (ks_data),
      .ks_ready   (ks_ready),
      .ct_valid   (ct_valid),
      .ct_data    (ct_data),
      .ct_ready   (ct_ready),
      .pt_valid   (pt_valid),
      .pt_data    (pt_data),
      .pt_ready   (pt_ready),
      .frame_done (frame_done),
      .ks_level   (ks_level)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic byte unsigned fold(input logic [31:0] d);
      int unsigned v = d;
      return byte'((v % 256) ^ ((v / 256) % 256) ^ ((v / 65536) % 128));
   endfunction

   task automatic model_reset();
      m_keys.delete();
      m_prev = 8'hA5;
      m_pix  = 0;
      m_pv   = 0;
      m_pd   = 0;
      m_fd   = 0;
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, then
   // advance the model by what the coming rising edge should do.
   task automatic step(input bit kv, input logic [31:0] kd, input bit cv,
                       input logic [7:0] cd, input bit pr);
      bit exp_ct_ready;
      bit push;
      bit fire;
      byte unsigned k;
      @(negedge clk);
      ks_valid = kv;
      ks_data  = kd;
      ct_valid = cv;
      ct_data  = cd;
      pt_ready = pr;
      #1;
      exp_ct_ready = (m_keys.size() > 0) && (!m_pv || pr);
      check_eq("pt_valid",   pt_valid,   m_pv);
      check_eq("pt_data",    pt_data,    m_pd);
      check_eq("frame_done", frame_done, m_fd);
      check_eq("ks_level",   ks_level,   m_keys.size());
      check_eq("ks_ready",   ks_ready,   m_keys.size() < DEPTH);
      check_eq("ct_ready",   ct_ready,   exp_ct_ready);
      push = kv && (m_keys.size() < DEPTH);
      fire = cv && exp_ct_ready;
      m_fd = 0;
      if (fire) begin
         k    = m_keys.pop_front();
`ifdef CHAIN_DIFFUSION_EN
         m_pd = cd ^ k ^ m_prev;
`else
         m_pd = cd ^ k;
`endif
         m_pv   = 1;
         m_prev = cd;
         m_pix++;
         if (m_pix == FRAME) begin
            m_pix  = 0;
            m_prev = 8'hA5;
            m_fd   = 1;
         end
      end else if (pr) begin
         m_pv = 0;
      end
      if (push) m_keys.push_back(fold(kd));
   endtask

   task automatic apply_reset(input bit check_now);
      @(negedge clk);
      ks_valid = 0;
      ks_data  = 0;
      ct_valid = 0;
      ct_data  = 0;
      pt_ready = 0;
      reset    = 1;
      #1;
      if (check_now) begin
         check_eq("rst_pt_valid",   pt_valid,   0);
         check_eq("rst_pt_data",    pt_data,    0);
         check_eq("rst_frame_done", frame_done, 0);
         check_eq("rst_ks_level",   ks_level,   0);
         check_eq("rst_ct_ready",   ct_ready,   0);
         check_eq("rst_ks_ready",   ks_ready,   1);
      end
      model_reset();
      repeat (2) @(negedge clk);
      reset = 0;
   endtask

   initial begin
      logic [7:0] e_first;
      logic [7:0] e_held;
      logic [7:0] e_fifth;
      reset    = 1;
      ks_valid = 0;
      ks_data  = 0;
      ct_valid = 0;
      ct_data  = 0;
      pt_ready = 0;
      model_reset();
      apply_reset(1'b1);

`ifdef CHAIN_DIFFUSION_EN
      e_first = 8'hD5;
      e_held  = 8'h2C;
      e_fifth = 8'h9B;
`else
      e_first = 8'h70;
      e_held  = 8'h76;
      e_fifth = 8'h3E;
`endif

      // Basic decrypt of two pixels
      step(0, 0, 0, 0, 1);
      step(1, 32'h3F12_3456, 0, 8'h00, 1);
      step(0, 0, 1, 8'h00, 1);
      step(0, 0, 0, 0, 1);
      check_eq("px0_data", pt_data, e_first);
      step(1, 32'h0000_0000, 0, 0, 1);
      step(0, 0, 1, 8'h11, 1);
      step(0, 0, 0, 0, 1);
      check_eq("px1_data", pt_data, 8'h11);

      // FIFO fill: keys 0..7 accepted, a ninth ignored
      for (int i = 0; i < 9; i++) step(1, FP_ONE | 32'(i), 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check_eq("full_level", ks_level, 8);
      check_eq("full_ready", ks_ready, 0);
      step(0, 0, 1, 8'h5A, 1);
      step(0, 0, 0, 0, 1);
      check_eq("pop_level", ks_level, 7);
      check_eq("pop_ready", ks_ready, 1);

      // Last pixel of frame fired, then held under backpressure
      step(0, 0, 1, 8'h77, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 8'h33, 0);
         check_eq("bp_ct_ready", ct_ready, 0);
         check_eq("bp_pt_data",  pt_data,  e_held);
         check_eq("bp_frame_done", frame_done, (i == 0) ? 1 : 0);
      end
      // First pixel of the next frame restarts chaining from the seed
      step(0, 0, 1, 8'h3C, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 8'(8'h10 + i), 1);
         check_eq("stream_valid", pt_valid, 1);
         if (i == 0) check_eq("px4_data", pt_data, e_fifth);
      end
      step(0, 0, 0, 0, 1);

      // Other FP constants fold to zero keys
      step(1, FP_HALF, 0, 0, 1);
      step(1, FP_NEG_ONE, 1, 8'h4B, 1);
      step(0, 0, 1, 8'hC3, 1);
      step(0, 0, 0, 0, 1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) < 50), $urandom(), ($urandom_range(0, 99) < 60),
              8'($urandom()), ($urandom_range(0, 99) < 70));
      end

      // Reset with three queued keys and a pending output
      apply_reset(1'b0);
      for (int i = 0; i < 4; i++) step(1, $urandom(), 0, 0, 1);
      step(0, 0, 1, 8'($urandom()), 0);
      step(0, 0, 0, 0, 0);
      check_eq("pre_rst_level", ks_level, 3);
      check_eq("pre_rst_valid", pt_valid, 1);
      apply_reset(1'b1);
      step(0, 0, 0, 0, 1);
      check_eq("post_rst_level", ks_level, 0);

      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 99) < 40), $urandom(), ($urandom_range(0, 99) < 70),
              8'($urandom()), ($urandom_range(0, 99) < 50));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
